// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the shift-and-add multiplier: state encoding, default
// width and carry recovery for the MSB-first ripple adder.
package shift_add_multiplier_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The adder exposes only its sum. The MSB carry-out is rebuilt from the top
    // operand bits and the top sum bit: when a0^b0 is 1, the carry-in was ~c0.
    function automatic logic recover_carry(input logic a0, input logic b0, input logic c0);
        return (a0 & b0) | ((a0 ^ b0) & ~c0);
    endfunction

endpackage

// File: rtl/shift_add_multiplier_adder.sv
// Combinational ripple-carry adder with MSB-first vectors (index 0 = MSB).
// Only the WIDTH-bit sum is produced; callers recover the carry-out themselves.
module shift_add_multiplier_adder #(
    parameter int WIDTH = 8
) (
    input  logic [0:WIDTH-1] op_a,
    input  logic [0:WIDTH-1] op_b,
    output logic [0:WIDTH-1] sum
);

    // carry_in[gi] is the carry entering bit gi; the LSB sits at index WIDTH-1.
    logic [0:WIDTH-1] carry_in;

    assign carry_in[WIDTH-1] = 1'b0;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign sum[gi] = op_a[gi] ^ op_b[gi] ^ carry_in[gi];
            if (gi > 0) begin : g_carry
                assign carry_in[gi-1] = (op_a[gi] & op_b[gi])
                                      | (op_a[gi] & carry_in[gi])
                                      | (op_b[gi] & carry_in[gi]);
            end
        end
    endgenerate

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned WIDTH x WIDTH shift-and-add multiplier with valid/ready
// handshakes on both sides; one operation in flight, fixed WIDTH-cycle latency.
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [0:WIDTH-1]     a,
    input  logic [0:WIDTH-1]     b,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic [0:2*WIDTH-1]   product,
    output logic                 busy
);

    localparam int COUNT_W = $clog2(WIDTH) + 1;

    state_t               state_reg;
    logic [COUNT_W-1:0]   count_reg;
    logic [0:WIDTH-1]     acc_hi_reg;
    logic [0:WIDTH-1]     acc_lo_reg;
    logic [0:WIDTH-1]     mcand_reg;
    logic [0:2*WIDTH-1]   product_reg;
    logic                 start_ready_reg;
    logic                 result_valid_reg;
    logic                 busy_reg;

    logic [0:WIDTH-1]     addend;
    logic [0:WIDTH-1]     sum;
    logic                 carry;
    logic [0:2*WIDTH-1]   acc_next;

    // Multiplicand is added only when the current multiplier LSB is set.
    assign addend = acc_lo_reg[WIDTH-1] ? mcand_reg : '0;

    shift_add_multiplier_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .op_a (acc_hi_reg),
        .op_b (addend),
        .sum  (sum)
    );

    assign carry    = recover_carry(acc_hi_reg[0], addend[0], sum[0]);
    // Right shift of {carry, sum, acc_lo}; the consumed multiplier bit drops off.
    assign acc_next = {carry, sum, acc_lo_reg[0:WIDTH-2]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= IDLE;
            count_reg        <= '0;
            acc_hi_reg       <= '0;
            acc_lo_reg       <= '0;
            mcand_reg        <= '0;
            product_reg      <= '0;
            start_ready_reg  <= 1'b1;
            result_valid_reg <= 1'b0;
            busy_reg         <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_valid) begin
                        mcand_reg       <= a;
                        acc_hi_reg      <= '0;
                        acc_lo_reg      <= b;
                        count_reg       <= '0;
                        state_reg       <= RUN;
                        start_ready_reg <= 1'b0;
                        busy_reg        <= 1'b1;
                    end
                end
                RUN: begin
                    {acc_hi_reg, acc_lo_reg} <= acc_next;
                    count_reg                <= count_reg + COUNT_W'(1);
                    if (count_reg == COUNT_W'(WIDTH - 1)) begin
                        state_reg        <= DONE;
                        product_reg      <= acc_next;
                        result_valid_reg <= 1'b1;
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        state_reg        <= IDLE;
                        result_valid_reg <= 1'b0;
                        start_ready_reg  <= 1'b1;
                        busy_reg         <= 1'b0;
                    end
                end
                default: begin
                    state_reg        <= IDLE;
                    result_valid_reg <= 1'b0;
                    start_ready_reg  <= 1'b1;
                    busy_reg         <= 1'b0;
                end
            endcase
        end
    end

    assign start_ready  = start_ready_reg;
    assign result_valid = result_valid_reg;
    assign product      = product_reg;
    assign busy         = busy_reg;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: directed cases plus random
// operands compared against a plain a*b reference.
module tb_shift_add_multiplier;

    localparam int W = 8;

    logic           clk;
    logic           rst;
    logic           start_valid;
    logic           start_ready;
    logic [0:W-1]   a;
    logic [0:W-1]   b;
    logic           result_valid;
    logic           result_ready;
    logic [0:2*W-1] product;
    logic           busy;

    int vectors;
    int miscompares;

    shift_add_multiplier #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .a            (a),
        .b            (b),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .product      (product),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge with the block idle; returns at the negedge after the
    // result handshake. inject drives a=1,b=1 with start_valid during RUN/DONE.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input int hold, input bit inject);
        logic [31:0] expected;
        int n;
        expected = 32'(ta) * 32'(tb_v);
        check("start_ready_idle", 32'(start_ready), 32'd1);
        start_valid = 1'b1;
        a = ta;
        b = tb_v;
        next_cycle();
        start_valid = inject;
        a = inject ? W'(1) : W'($urandom);
        b = inject ? W'(1) : W'($urandom);
        n = 0;
        while (result_valid !== 1'b1 && n < 20) begin
            if (inject) check("start_ready_run", 32'(start_ready), 32'd0);
            next_cycle();
            n++;
        end
        check("latency", 32'(n), 32'(W));
        check("product", 32'(product), expected);
        check("busy_done", 32'(busy), 32'd1);
        for (int i = 0; i < hold; i++) begin
            next_cycle();
            check("hold_valid", 32'(result_valid), 32'd1);
            check("hold_product", 32'(product), expected);
            check("hold_start_ready", 32'(start_ready), 32'd0);
        end
        start_valid  = 1'b0;
        result_ready = 1'b1;
        next_cycle();
        result_ready = 1'b0;
        check("valid_after_hs", 32'(result_valid), 32'd0);
        check("ready_after_hs", 32'(start_ready), 32'd1);
        check("product_kept", 32'(product), expected);
        $display("op a=%02h b=%02h product=%04h expected=%04h latency=%0d",
                 ta, tb_v, product, expected[15:0], n);
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst          = 1'b1;
        start_valid  = 1'b0;
        result_ready = 1'b0;
        a            = '0;
        b            = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_start_ready", 32'(start_ready), 32'd1);
        check("rst_result_valid", 32'(result_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_product", 32'(product), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(8'd3, 8'd5, 0, 1'b0);
        run_op(8'hFF, 8'hFF, 0, 1'b0);
        run_op(8'h92, 8'hAB, 1, 1'b0);
        run_op(8'h00, 8'h7F, 0, 1'b0);
        run_op(8'h7F, 8'h00, 0, 1'b0);
        run_op(8'hC3, 8'h5A, 5, 1'b1);

        // Abort mid-RUN: after accept plus four RUN edges, count is 4.
        start_valid = 1'b1;
        a = 8'h55;
        b = 8'h33;
        next_cycle();
        start_valid = 1'b0;
        repeat (4) next_cycle();
        check("busy_before_abort", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_start_ready", 32'(start_ready), 32'd1);
        check("abort_result_valid", 32'(result_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_product", 32'(product), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            next_cycle();
            check("no_result_after_abort", 32'(result_valid), 32'd0);
        end
        run_op(8'd2, 8'd2, 0, 1'b0);

        // Back-to-back with random holds and occasional ignored requests.
        for (int i = 0; i < 1000; i++) begin
            run_op(W'($urandom), W'($urandom), int'($urandom_range(0, 2)),
                   bit'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
